frame_stream_source: RTL and testbench

AXI-Stream master that replays a stored frame of DW-bit samples to downstream consumers such as the prominence analyser. Software or a capture path fills an internal single-port-write / synchronous-read buffer. A start command then streams entries 0..frame_len_m1 with tuser on the first beat and tlast on the last. It supports one-shot and continuous (back-to-back frame) modes, full tready backpressure, and 1 beat/cycle throughput.

---
 rtl/frame_stream_source.sv | 198 +++++++++++++++++++
 tb/tb_frame_stream_source.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_source.sv
// AXI-Stream replay of a stored frame from a 2^AW x DW buffer, one-shot or continuous.
// Optional FRAME_SRC_RAMP_EN adds ramp_sel: data field becomes the zero-extended read pointer.
module frame_stream_source #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          cont,
    input  logic [AW-1:0] frame_len_m1,
`ifdef FRAME_SRC_RAMP_EN
    input  logic          ramp_sel,
`endif
    output logic [DW-1:0] tdata_m,
    output logic          tuser_m,
    output logic          tlast_m,
    output logic          tvalid_m,
    input  logic          tready_m,
    output logic          busy,
    output logic          done
);

    // state  | meaning
    // IDLE   | waiting for start
    // STREAM | issuing buffer reads 0..len_q, wrapping when cont is set
    // DRAIN  | reads finished, waiting for the last beat to handshake
    // DONE   | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] len_q, len_d;
    logic          ramp_q, ramp_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_first_q, rd_first_d;
    logic          rd_last_q, rd_last_d;
    logic          rd_ramp_q, rd_ramp_d;
    logic [AW-1:0] rd_ptr_dly_q, rd_ptr_dly_d;
    logic [DW-1:0] h_data_q, h_data_d, t_data_q, t_data_d;
    logic          h_first_q, h_first_d, t_first_q, t_first_d;
    logic          h_last_q, h_last_d, t_last_q, t_last_d;
    logic [1:0]    cnt_q, cnt_d;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;
    logic          ramp_in;
    logic          rd_issue;
    logic          pop;
    logic [2:0]    occ;
    logic [DW-1:0] push_data;

`ifdef FRAME_SRC_RAMP_EN
    assign ramp_in = ramp_sel;
`else
    assign ramp_in = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        ramp_d       = ramp_q;
        rd_issue     = 1'b0;
        pop          = ce && (cnt_q != 2'd0) && tready_m;
        // Occupancy after this cycle's pop plus the read already in flight.
        occ          = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = frame_len_m1;
                    ramp_d   = ramp_in;
                    rd_ptr_d = '0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (occ < 3'd2) begin
                    rd_issue = 1'b1;
                    if (rd_ptr_q == len_q) begin
                        if (cont) begin
                            len_d    = frame_len_m1;
                            ramp_d   = ramp_in;
                            rd_ptr_d = '0;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && h_last_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        rd_vld_d     = rd_issue;
        rd_first_d   = (rd_ptr_q == '0);
        rd_last_d    = (rd_ptr_q == len_q);
        rd_ramp_d    = ramp_q;
        rd_ptr_dly_d = rd_ptr_q;
    end

    always_comb begin
        push_data = rd_ramp_q ? DW'(rd_ptr_dly_q) : rd_data_q;
        h_data_d  = h_data_q;
        h_first_d = h_first_q;
        h_last_d  = h_last_q;
        t_data_d  = t_data_q;
        t_first_d = t_first_q;
        t_last_d  = t_last_q;
        cnt_d     = cnt_q;
        case ({rd_vld_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    h_data_d = push_data; h_first_d = rd_first_q; h_last_d = rd_last_q;
                end else begin
                    t_data_d = push_data; t_first_d = rd_first_q; t_last_d = rd_last_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                h_data_d = t_data_q; h_first_d = t_first_q; h_last_d = t_last_q;
                cnt_d    = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    h_data_d = push_data; h_first_d = rd_first_q; h_last_d = rd_last_q;
                end else begin
                    h_data_d = t_data_q; h_first_d = t_first_q; h_last_d = t_last_q;
                    t_data_d = push_data; t_first_d = rd_first_q; t_last_d = rd_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            ramp_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_ramp_q    <= 1'b0;
            rd_ptr_dly_q <= '0;
            h_data_q     <= '0;
            h_first_q    <= 1'b0;
            h_last_q     <= 1'b0;
            t_data_q     <= '0;
            t_first_q    <= 1'b0;
            t_last_q     <= 1'b0;
            cnt_q        <= 2'd0;
        end else if (ce) begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            ramp_q       <= ramp_d;
            rd_vld_q     <= rd_vld_d;
            rd_first_q   <= rd_first_d;
            rd_last_q    <= rd_last_d;
            rd_ramp_q    <= rd_ramp_d;
            rd_ptr_dly_q <= rd_ptr_dly_d;
            h_data_q     <= h_data_d;
            h_first_q    <= h_first_d;
            h_last_q     <= h_last_d;
            t_data_q     <= t_data_d;
            t_first_q    <= t_first_d;
            t_last_q     <= t_last_d;
            cnt_q        <= cnt_d;
        end
    end

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_issue) rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign tdata_m  = h_data_q;
    assign tuser_m  = h_first_q;
    assign tlast_m  = h_last_q;
    assign tvalid_m = (cnt_q != 2'd0);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_stream_source.sv
// Randomized bench for frame_stream_source: every presented beat is compared against a frame model.
module tb_frame_stream_source;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n, ce, wr_en, start, cont, tready_m;
    logic [AW-1:0] wr_addr, frame_len_m1;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] tdata_m;
    logic          tuser_m, tlast_m, tvalid_m, busy, done;
`ifdef FRAME_SRC_RAMP_EN
    logic          ramp_sel = 1'b0;
`endif

    frame_stream_source #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .cont(cont), .frame_len_m1(frame_len_m1),
`ifdef FRAME_SRC_RAMP_EN
        .ramp_sel(ramp_sel),
`endif
        .tdata_m(tdata_m), .tuser_m(tuser_m), .tlast_m(tlast_m),
        .tvalid_m(tvalid_m), .tready_m(tready_m),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame model: buffer image plus the index of the next beat expected at the head.
    logic [DW-1:0] model_mem [2**AW];
    bit            mon_en   = 1'b0;
    bit            mon_ramp = 1'b0;
    int            mon_idx, mon_len, mon_beats, done_cnt, first_cyc, last_cyc;
    int            cyc = 0;
    int            ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic [DW-1:0] exp_d;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tready_m = 1'b0;
                1:       tready_m = 1'b1;
                default: tready_m = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (mon_en && reset_n) begin
            if (ce && done) done_cnt++;
            if (tvalid_m) begin
                exp_d = mon_ramp ? DW'(mon_idx) : model_mem[mon_idx];
                check("beat_data", 32'(tdata_m), 32'(exp_d));
                check("beat_tuser", 32'(tuser_m), 32'(mon_idx == 0));
                check("beat_tlast", 32'(tlast_m), 32'(mon_idx == mon_len));
                if (tready_m && ce) begin
                    mon_beats++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    mon_idx  = (mon_idx == mon_len) ? 0 : mon_idx + 1;
                end
            end
        end
    end

    task automatic write_buf(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        model_mem[addr] = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Entered and left at posedge+1.
    task automatic start_frame(input int len, input bit c, input bit chk_lat);
        mon_idx      = 0;
        mon_len      = len;
        mon_beats    = 0;
        done_cnt     = 0;
        first_cyc    = -1;
        last_cyc     = -1;
        frame_len_m1 = AW'(len);
        cont         = c;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            @(negedge clk);
            check("lat_n1_tvalid", 32'(tvalid_m), 32'd0);
            @(negedge clk);
            check("lat_n2_tvalid", 32'(tvalid_m), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_frame(input int exp_beats, input int min_beats, input bit strict);
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("end_on_frame_boundary", 32'(mon_idx), 32'd0);
        if (exp_beats >= 0) check("beat_count", 32'(mon_beats), 32'(exp_beats));
        else check("beat_count_min", 32'(mon_beats >= min_beats), 32'd1);
        if (strict) check("no_bubbles", 32'(last_cyc - first_cyc + 1), 32'(mon_beats));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        reset_n = 1'b0; ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; cont = 1'b0; frame_len_m1 = '0; tready_m = 1'b1;
        #1;
        check("rst_tvalid", 32'(tvalid_m), 32'd0);
        check("rst_tuser", 32'(tuser_m), 32'd0);
        check("rst_tlast", 32'(tlast_m), 32'd0);
        check("rst_tdata", 32'(tdata_m), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < 2**AW; i++)
            write_buf(i, (i < 4) ? DW'((i + 1) * 16) : DW'($urandom));

        // One-shot, full throughput, latency checked.
        ready_mode = 1;
        start_frame(3, 1'b0, 1'b1);
        finish_frame(4, 0, 1'b1);

        // Single-beat frame.
        start_frame(0, 1'b0, 1'b1);
        finish_frame(1, 0, 1'b1);

        // Backpressure with random ready, random short lengths.
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            len = (r == 0) ? 3 : int'($urandom_range(0, 15));
            start_frame(len, 1'b0, 1'b1);
            finish_frame(len + 1, 0, 1'b0);
        end

        // Continuous, full throughput across frame boundaries.
        ready_mode = 1;
        start_frame(2, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        cont = 1'b0;
        finish_frame(-1, 6, 1'b1);

        // Continuous with backpressure.
        ready_mode = 2;
        for (int r = 0; r < 3; r++) begin
            len = int'($urandom_range(0, 5));
            start_frame(len, 1'b1, 1'b0);
            repeat (20) @(posedge clk);
            #1;
            cont = 1'b0;
            finish_frame(-1, len + 1, 1'b0);
        end

        // Whole buffer.
        ready_mode = 1;
        start_frame(2**AW - 1, 1'b0, 1'b1);
        finish_frame(2**AW, 0, 1'b1);

        // Clock enable freeze mid-frame with a full output FIFO.
        ready_mode = 0;
        start_frame(30, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        ce = 1'b0;
        ready_mode = 2;
        repeat (5) begin
            @(negedge clk);
            check("ce_freeze_tvalid", 32'(tvalid_m), 32'd1);
            check("ce_freeze_busy", 32'(busy), 32'd1);
            check("ce_freeze_beats", 32'(mon_beats), 32'd0);
        end
        @(posedge clk);
        #1;
        ce = 1'b1;
        finish_frame(31, 0, 1'b0);

        // Asynchronous reset mid-frame, then restart from address 0.
        ready_mode = 2;
        start_frame(20, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_tvalid", 32'(tvalid_m), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) write_buf(i, DW'($urandom));
        mon_en = 1'b1;
        start_frame(4, 1'b0, 1'b1);
        finish_frame(5, 0, 1'b0);

`ifdef FRAME_SRC_RAMP_EN
        ready_mode = 2;
        ramp_sel = 1'b1;
        mon_ramp = 1'b1;
        start_frame(4, 1'b0, 1'b1);
        ramp_sel = 1'b0;
        finish_frame(5, 0, 1'b0);
        mon_ramp = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
